// File: rtl/starfield_ctl_pkg.sv
// Shared types and constants for the starfield register-write sequencer.
package starfield_ctl_pkg;

    typedef logic signed [15:0] vel_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_WR_EN = 3'd2,
        ST_WR_HH = 3'd3,
        ST_WR_HL = 3'd4,
        ST_WR_VH = 3'd5,
        ST_WR_VL = 3'd6
    } state_e;

    localparam logic [2:0] ADDR_EN  = 3'd0;
    localparam logic [2:0] ADDR_HHI = 3'd1;
    localparam logic [2:0] ADDR_HLO = 3'd2;
    localparam logic [2:0] ADDR_VHI = 3'd3;
    localparam logic [2:0] ADDR_VLO = 3'd4;

    localparam vel_t VEL_NEG_MAX = 16'sh8000;
    localparam vel_t VEL_NEG_LIM = 16'sh8001;

    // -32768 has no 15-bit magnitude, so it is pulled in to -32767.
    function automatic vel_t clamp_vel(input vel_t v);
        vel_t r;
        if (v == VEL_NEG_MAX) begin
            r = VEL_NEG_LIM;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/starfield_ctl_if.sv
// Request handshake and starfield write-port bundle for starfield_ctl.
interface starfield_ctl_if;
    import starfield_ctl_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic       req_en;
    vel_t       req_h;
    vel_t       req_v;
    logic [2:0] addr;
    logic [7:0] data_out;
    logic       write;
    logic       busy;

    modport master (
        output req_valid, req_en, req_h, req_v,
        input  req_ready, addr, data_out, write, busy
    );

    modport slave (
        input  req_valid, req_en, req_h, req_v,
        output req_ready, addr, data_out, write, busy
    );

endinterface

// File: rtl/starfield_axis_step.sv
// Per-axis velocity stepper plus sign-magnitude byte encoder (combinational).
// Ramp rate depends on STARFIELD_RAMP_EN.
module starfield_axis_step
    import starfield_ctl_pkg::*;
#(
    parameter logic [15:0] STEP = 16'd64
) (
    input  vel_t       cur_i,
    input  vel_t       tgt_i,
    input  vel_t       enc_i,
    output vel_t       nxt_o,
    output logic       changed_o,
    output logic [7:0] hi_o,
    output logic [7:0] lo_o
);

`ifdef STARFIELD_RAMP_EN
    localparam logic signed [18:0] STEP_X = {3'b000, STEP};
`else
    // Step exceeds any reachable cur/tgt distance, so the clamp always lands on the target.
    localparam logic signed [18:0] STEP_X = {3'b001, STEP};
`endif

    logic signed [18:0] cur_x_s;
    logic signed [18:0] tgt_x_s;
    logic signed [18:0] up_x_s;
    logic signed [18:0] dn_x_s;
    logic [14:0]        mag_s;

    assign cur_x_s = {{3{cur_i[15]}}, cur_i};
    assign tgt_x_s = {{3{tgt_i[15]}}, tgt_i};
    assign up_x_s  = cur_x_s + STEP_X;
    assign dn_x_s  = cur_x_s - STEP_X;

    // Move toward the target without overshooting it.
    always_comb begin
        nxt_o = cur_i;
        if (cur_x_s < tgt_x_s) begin
            if (up_x_s > tgt_x_s) begin
                nxt_o = tgt_i;
            end else begin
                nxt_o = up_x_s[15:0];
            end
        end else if (cur_x_s > tgt_x_s) begin
            if (dn_x_s < tgt_x_s) begin
                nxt_o = tgt_i;
            end else begin
                nxt_o = dn_x_s[15:0];
            end
        end else begin
            nxt_o = cur_i;
        end
    end

    assign changed_o = (nxt_o != cur_i);

    // Sign-magnitude split: dir=1 for non-negative values.
    always_comb begin
        mag_s = 15'd0;
        if (enc_i[15]) begin
            mag_s = 15'(-enc_i);
        end else begin
            mag_s = enc_i[14:0];
        end
        hi_o = {~enc_i[15], mag_s[14:8]};
        lo_o = mag_s[7:0];
    end

endmodule

// File: rtl/starfield_ctl.sv
// Starfield register-write sequencer: ramps velocity once per vblank and writes
// only dirty registers. Ramp stepping is enabled by STARFIELD_RAMP_EN.
module starfield_ctl
    import starfield_ctl_pkg::*;
#(
    parameter logic [15:0] STEP = 16'd64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vblank,
    starfield_ctl_if.slave  bus
);

    state_e     state_q, state_d;
    vel_t       tgt_h_q, tgt_h_d;
    vel_t       tgt_v_q, tgt_v_d;
    logic       tgt_en_q, tgt_en_d;
    vel_t       cur_h_q, cur_h_d;
    vel_t       cur_v_q, cur_v_d;
    logic       cur_en_q, cur_en_d;
    logic       d_en_q, d_en_d;
    logic       d_h_q, d_h_d;
    logic       d_v_q, d_v_d;
    logic       vb_pend_q, vb_pend_d;
    logic       vblank_q;
    logic [2:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       write_q, write_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;

    logic       vb_edge_s;
    logic       accept_s;
    vel_t       h_nxt_s, v_nxt_s;
    logic       h_chg_s, v_chg_s;
    logic [7:0] h_hi_s, h_lo_s, v_hi_s, v_lo_s;

    assign vb_edge_s = vblank & ~vblank_q;
    assign accept_s  = bus.req_valid & ready_q;

    starfield_axis_step #(.STEP(STEP)) u_axis_h (
        .cur_i     (cur_h_q),
        .tgt_i     (tgt_h_q),
        .enc_i     (cur_h_d),
        .nxt_o     (h_nxt_s),
        .changed_o (h_chg_s),
        .hi_o      (h_hi_s),
        .lo_o      (h_lo_s)
    );

    starfield_axis_step #(.STEP(STEP)) u_axis_v (
        .cur_i     (cur_v_q),
        .tgt_i     (tgt_v_q),
        .enc_i     (cur_v_d),
        .nxt_o     (v_nxt_s),
        .changed_o (v_chg_s),
        .hi_o      (v_hi_s),
        .lo_o      (v_lo_s)
    );

    // Sequencer next state, targets, current values and dirty flags.
    always_comb begin
        state_d   = state_q;
        tgt_h_d   = tgt_h_q;
        tgt_v_d   = tgt_v_q;
        tgt_en_d  = tgt_en_q;
        cur_h_d   = cur_h_q;
        cur_v_d   = cur_v_q;
        cur_en_d  = cur_en_q;
        d_en_d    = d_en_q;
        d_h_d     = d_h_q;
        d_v_d     = d_v_q;
        vb_pend_d = vb_pend_q;

        if (accept_s) begin
            tgt_h_d  = clamp_vel(bus.req_h);
            tgt_v_d  = clamp_vel(bus.req_v);
            tgt_en_d = bus.req_en;
        end else begin
            tgt_en_d = tgt_en_q;
        end

        // Consuming the pending frame takes priority; edges seen while pending are dropped.
        if ((state_q == ST_IDLE) && vb_pend_q) begin
            vb_pend_d = 1'b0;
        end else if (vb_edge_s) begin
            vb_pend_d = 1'b1;
        end else begin
            vb_pend_d = vb_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (vb_pend_q) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                cur_h_d  = h_nxt_s;
                cur_v_d  = v_nxt_s;
                cur_en_d = tgt_en_q;
                d_en_d   = d_en_q | (tgt_en_q != cur_en_q);
                d_h_d    = d_h_q | h_chg_s;
                d_v_d    = d_v_q | v_chg_s;
                if (d_en_d) begin
                    state_d = ST_WR_EN;
                end else if (d_h_d) begin
                    state_d = ST_WR_HH;
                end else if (d_v_d) begin
                    state_d = ST_WR_VH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_EN: begin
                d_en_d = 1'b0;
                if (d_h_q) begin
                    state_d = ST_WR_HH;
                end else if (d_v_q) begin
                    state_d = ST_WR_VH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_HH: begin
                state_d = ST_WR_HL;
            end
            ST_WR_HL: begin
                d_h_d = 1'b0;
                if (d_v_q) begin
                    state_d = ST_WR_VH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_VH: begin
                state_d = ST_WR_VL;
            end
            ST_WR_VL: begin
                d_v_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write port is driven from the state being entered so outputs can be registered.
    always_comb begin
        write_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_d)
            ST_WR_EN: begin
                write_d = 1'b1;
                addr_d  = ADDR_EN;
                data_d  = {7'b0000000, cur_en_d};
            end
            ST_WR_HH: begin
                write_d = 1'b1;
                addr_d  = ADDR_HHI;
                data_d  = h_hi_s;
            end
            ST_WR_HL: begin
                write_d = 1'b1;
                addr_d  = ADDR_HLO;
                data_d  = h_lo_s;
            end
            ST_WR_VH: begin
                write_d = 1'b1;
                addr_d  = ADDR_VHI;
                data_d  = v_hi_s;
            end
            ST_WR_VL: begin
                write_d = 1'b1;
                addr_d  = ADDR_VLO;
                data_d  = v_lo_s;
            end
            default: begin
                write_d = 1'b0;
                addr_d  = addr_q;
                data_d  = data_q;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset leaves every group dirty for a full refresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tgt_h_q   <= 16'sd0;
            tgt_v_q   <= 16'sd0;
            tgt_en_q  <= 1'b0;
            cur_h_q   <= 16'sd0;
            cur_v_q   <= 16'sd0;
            cur_en_q  <= 1'b0;
            d_en_q    <= 1'b1;
            d_h_q     <= 1'b1;
            d_v_q     <= 1'b1;
            vb_pend_q <= 1'b0;
            vblank_q  <= 1'b0;
            addr_q    <= 3'd0;
            data_q    <= 8'd0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            tgt_h_q   <= tgt_h_d;
            tgt_v_q   <= tgt_v_d;
            tgt_en_q  <= tgt_en_d;
            cur_h_q   <= cur_h_d;
            cur_v_q   <= cur_v_d;
            cur_en_q  <= cur_en_d;
            d_en_q    <= d_en_d;
            d_h_q     <= d_h_d;
            d_v_q     <= d_v_d;
            vb_pend_q <= vb_pend_d;
            vblank_q  <= vblank;
            addr_q    <= addr_d;
            data_q    <= data_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.addr      = addr_q;
    assign bus.data_out  = data_q;
    assign bus.write     = write_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_starfield_ctl.sv
// Directed-vector bench for starfield_ctl; expectations follow STARFIELD_RAMP_EN.
module tb_starfield_ctl;
    import starfield_ctl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic vblank;
    starfield_ctl_if bus ();

    starfield_ctl #(.STEP(16'd64)) dut (
        .clk    (clk),
        .rst    (rst),
        .vblank (vblank),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];
    int          wcyc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          frame_n0 = 0;

    always @(negedge clk) begin
        if (bus.write === 1'b1) begin
            got_q.push_back({bus.addr, bus.data_out});
            wcyc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expw(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic exp_refresh();
        expw(3'd0, 8'h00); expw(3'd1, 8'h80); expw(3'd2, 8'h00);
        expw(3'd3, 8'h80); expw(3'd4, 8'h00);
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_w%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
        wcyc_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got_q.delete();
        wcyc_q.delete();
    endtask

    task automatic pulse_vblank();
        vblank   = 1'b1;
        frame_n0 = cyc;
        @(negedge clk);
        vblank = 1'b0;
    endtask

    task automatic run_frame();
        pulse_vblank();
        repeat (12) @(negedge clk);
    endtask

    task automatic send_req(input logic en, input logic [15:0] h, input logic [15:0] v,
                            output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        bus.req_valid = 1'b1;
        bus.req_en    = en;
        bus.req_h     = h;
        bus.req_v     = v;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        bus.req_valid = 1'b0;
        check_eq("req_accept", int'(ok), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int any_busy;
        logic found;
`ifdef STARFIELD_RAMP_EN
        logic [7:0] lo_tab [4];
        lo_tab = '{8'h40, 8'h80, 8'hC0, 8'hC8};
`endif
        rst = 1'b1;
        vblank = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_en = 1'b0;
        bus.req_h = 16'h0000;
        bus.req_v = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("rst_addr",  int'(bus.addr), 0);
        check_eq("rst_data",  int'(bus.data_out), 0);
        check_eq("rst_write", int'(bus.write), 0);
        check_eq("rst_busy",  int'(bus.busy), 0);
        check_eq("rst_ready", int'(bus.req_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // Full refresh after reset, with latency check
        run_frame();
        check_eq("first_wr_cyc", (wcyc_q.size() > 0) ? wcyc_q[0] : -1, frame_n0 + 3);
        check_eq("last_wr_cyc",  (wcyc_q.size() > 4) ? wcyc_q[4] : -1, frame_n0 + 7);
        check_eq("idle_busy", int'(bus.busy), 0);
        exp_refresh();
        compare_writes("refresh");

        // h = +200
        send_req(1'b0, 16'd200, 16'd0, w);
`ifdef STARFIELD_RAMP_EN
        for (int f = 0; f < 4; f++) begin
            run_frame();
            expw(3'd1, 8'h80); expw(3'd2, lo_tab[f]);
            compare_writes($sformatf("ramp_h200_f%0d", f));
        end
`else
        run_frame();
        expw(3'd1, 8'h80); expw(3'd2, 8'hC8);
        compare_writes("h200");
`endif
        run_frame();
        compare_writes("h200_settled");

        // h = -300 then -32768 from zero
        do_reset();
        run_frame();
        exp_refresh();
        compare_writes("refresh2");
        send_req(1'b0, 16'hFED4, 16'd0, w);
        run_frame();
`ifdef STARFIELD_RAMP_EN
        expw(3'd1, 8'h00); expw(3'd2, 8'h40);
`else
        expw(3'd1, 8'h01); expw(3'd2, 8'h2C);
`endif
        compare_writes("hneg300");
        send_req(1'b0, 16'h8000, 16'd0, w);
        run_frame();
`ifdef STARFIELD_RAMP_EN
        expw(3'd1, 8'h00); expw(3'd2, 8'h80);
`else
        expw(3'd1, 8'h7F); expw(3'd2, 8'hFF);
`endif
        compare_writes("hclamp");

        // Enable only, then request held while busy
        do_reset();
        run_frame();
        exp_refresh();
        compare_writes("refresh3");
        send_req(1'b1, 16'd0, 16'd0, w);
        pulse_vblank();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.write === 1'b1) begin
                found = 1'b1;
                break;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("en_wr_seen", int'(found), 1);
        check_eq("busy_in_wr", int'(bus.busy), 1);
        check_eq("ready_in_wr", int'(bus.req_ready), 0);
        send_req(1'b1, 16'd0, 16'h0100, w);
        check_eq("held_req_wait", w, 1);
        repeat (5) @(negedge clk);
        expw(3'd0, 8'h01);
        compare_writes("en_only");
        run_frame();
`ifdef STARFIELD_RAMP_EN
        expw(3'd3, 8'h80); expw(3'd4, 8'h40);
`else
        expw(3'd3, 8'h81); expw(3'd4, 8'h00);
`endif
        compare_writes("v256");

        // Second edge during WR_HL is queued; third is dropped
        do_reset();
        run_frame();
        exp_refresh();
        compare_writes("refresh4");
        send_req(1'b1, 16'd5, 16'd3, w);
        pulse_vblank();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.write === 1'b1 && bus.addr === 3'd2) begin
                found = 1'b1;
                break;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("hl_wr_seen", int'(found), 1);
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        check_eq("gap_idle", int'(bus.busy), 0);
        @(negedge clk);
        check_eq("pend_step", int'(bus.busy), 1);
        any_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy === 1'b1) any_busy++;
        end
        check_eq("third_edge_dropped", any_busy, 0);
        expw(3'd0, 8'h01); expw(3'd1, 8'h80); expw(3'd2, 8'h05);
        expw(3'd3, 8'h80); expw(3'd4, 8'h03);
        compare_writes("double_vb");

        // Reset during WR_VH
        do_reset();
        pulse_vblank();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.write === 1'b1 && bus.addr === 3'd3) begin
                found = 1'b1;
                break;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("vh_wr_seen", int'(found), 1);
        rst = 1'b1;
        #1;
        check_eq("rst_async_write", int'(bus.write), 0);
        check_eq("rst_async_busy", int'(bus.busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got_q.delete();
        wcyc_q.delete();
        run_frame();
        exp_refresh();
        compare_writes("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
